// File: rtl/instr_prefetch_pkg.sv
// Shared types and constants for the instruction prefetch unit.
package instr_prefetch_pkg;

  localparam int          INSTR_W = 32;
  localparam logic [31:0] PC_STEP = 32'd4;

  // Fetch control states
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2
  } state_t;

  // One prefetched instruction together with its address
  typedef struct packed {
    logic [INSTR_W-1:0] pc;
    logic [INSTR_W-1:0] instr;
  } fetch_entry_t;

  // Force an address onto a word boundary
  function automatic logic [31:0] align_word(input logic [31:0] addr);
    return addr & 32'hFFFF_FFFC;
  endfunction

endpackage

// File: rtl/instr_prefetch_fifo.sv
// prefetch_fifo: ring buffer followed by a registered head stage.
// A pushed entry lands in the ring first and reaches the head register on the
// following edge, so the head appears one cycle after the push. count_o covers
// both the ring and the head register.
module prefetch_fifo
  import instr_prefetch_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   push_i,
  input  fetch_entry_t           push_data_i,
  input  logic                   pop_i,
  input  logic                   flush_i,
  output logic                   head_valid_o,
  output fetch_entry_t           head_o,
  output logic [$clog2(DEPTH):0] count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  fetch_entry_t   mem [DEPTH];
  logic [AW-1:0]  wr_ptr_reg;
  logic [AW-1:0]  rd_ptr_reg;
  logic [CW-1:0]  mem_cnt_reg;
  logic [CW-1:0]  mem_cnt_next;
  logic           head_valid_reg;
  fetch_entry_t   head_reg;
  logic           push_en;
  logic           load;

  // Flush outranks push; the head reloads whenever it is empty or being consumed
  assign push_en = push_i & ~flush_i;
  assign load    = (~head_valid_reg | pop_i) & (mem_cnt_reg != '0);

  // Ring occupancy after this cycle's push and head reload
  always_comb begin
    mem_cnt_next = mem_cnt_reg;
    if (push_en && !load)
      mem_cnt_next = mem_cnt_reg + CW'(1);
    else if (!push_en && load)
      mem_cnt_next = mem_cnt_reg - CW'(1);
  end

  // Storage array write port (no reset so it maps onto RAM)
  always_ff @(posedge clk_i) begin
    if (push_en)
      mem[wr_ptr_reg] <= push_data_i;
  end

  // Pointers, occupancy and the registered head stage
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_reg     <= '0;
      rd_ptr_reg     <= '0;
      mem_cnt_reg    <= '0;
      head_valid_reg <= 1'b0;
      head_reg       <= '0;
    end else if (flush_i) begin
      wr_ptr_reg     <= '0;
      rd_ptr_reg     <= '0;
      mem_cnt_reg    <= '0;
      head_valid_reg <= 1'b0;
    end else begin
      if (push_en)
        wr_ptr_reg <= wr_ptr_reg + AW'(1);
      if (load) begin
        rd_ptr_reg     <= rd_ptr_reg + AW'(1);
        head_reg       <= mem[rd_ptr_reg];
        head_valid_reg <= 1'b1;
      end else if (pop_i) begin
        head_valid_reg <= 1'b0;
      end
      mem_cnt_reg <= mem_cnt_next;
    end
  end

  assign head_valid_o = head_valid_reg;
  assign head_o       = head_reg;
  assign count_o      = mem_cnt_reg + CW'(head_valid_reg);

endmodule

// File: rtl/instr_prefetch.sv
// instr_prefetch: fetches sequential instruction words into a small FIFO and
// handles CPU redirects, draining any in-flight read whose data is now stale.
// Optional build macro PREFETCH_PERF_EN adds flush/stall performance counters.
module instr_prefetch
  import instr_prefetch_pkg::*;
#(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  output logic        mem_req_o,
  output logic [31:0] mem_addr_o,
  input  logic        mem_ack_i,
  input  logic [31:0] mem_data_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_addr_i,
  output logic        instr_valid_o,
  output logic [31:0] instr_o,
  output logic [31:0] instr_pc_o,
`ifdef PREFETCH_PERF_EN
  output logic [15:0] flush_cnt_o,
  output logic [15:0] stall_cnt_o,
`endif
  input  logic        instr_ready_i
);

  localparam int            CW      = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  state_t        state_reg, state_next;
  logic [31:0]   fetch_pc_reg, fetch_pc_next;
  logic          req_reg, req_next;
  logic [31:0]   addr_reg, addr_next;
  logic [31:0]   redirect_pc;
  logic [31:0]   pc_inc;
  logic          push;
  logic          pop;
  logic [CW-1:0] fifo_count;
  logic [CW-1:0] count_after;
  fetch_entry_t  push_entry;
  fetch_entry_t  head;
  logic          head_valid;

  assign redirect_pc = align_word(redirect_addr_i);
  assign pc_inc      = fetch_pc_reg + PC_STEP;
  // A word is kept only if it completes a live fetch not overruled by a redirect
  assign push        = (state_reg == FETCH) & mem_ack_i & ~redirect_i;
  assign pop         = head_valid & instr_ready_i;
  assign count_after = fifo_count + CW'(push) - CW'(pop);
  assign push_entry  = '{pc: fetch_pc_reg, instr: mem_data_i};

  prefetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .push_i       (push),
    .push_data_i  (push_entry),
    .pop_i        (pop),
    .flush_i      (redirect_i),
    .head_valid_o (head_valid),
    .head_o       (head),
    .count_o      (fifo_count)
  );

  // Next-state logic: request issue, back-to-back fetch, redirect and drain
  always_comb begin
    state_next    = state_reg;
    fetch_pc_next = fetch_pc_reg;
    req_next      = req_reg;
    addr_next     = addr_reg;
    case (state_reg)
      IDLE: begin
        if (redirect_i) begin
          fetch_pc_next = redirect_pc;
        end else if (start_i && (fifo_count < DEPTH_C)) begin
          state_next = FETCH;
          req_next   = 1'b1;
          addr_next  = fetch_pc_reg;
        end
      end
      FETCH: begin
        if (mem_ack_i) begin
          if (redirect_i) begin
            fetch_pc_next = redirect_pc;
            state_next    = IDLE;
            req_next      = 1'b0;
          end else begin
            fetch_pc_next = pc_inc;
            if (start_i && (count_after < DEPTH_C)) begin
              addr_next = pc_inc;
            end else begin
              state_next = IDLE;
              req_next   = 1'b0;
            end
          end
        end else if (redirect_i) begin
          fetch_pc_next = redirect_pc;
          state_next    = DRAIN;
        end
      end
      DRAIN: begin
        if (redirect_i)
          fetch_pc_next = redirect_pc;
        if (mem_ack_i) begin
          state_next = IDLE;
          req_next   = 1'b0;
        end
      end
      default: begin
        state_next = IDLE;
        req_next   = 1'b0;
      end
    endcase
  end

  // Fetch state, fetch address and registered memory request
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_reg    <= IDLE;
      fetch_pc_reg <= RESET_PC;
      req_reg      <= 1'b0;
      addr_reg     <= '0;
    end else begin
      state_reg    <= state_next;
      fetch_pc_reg <= fetch_pc_next;
      req_reg      <= req_next;
      addr_reg     <= addr_next;
    end
  end

  assign mem_req_o     = req_reg;
  assign mem_addr_o    = addr_reg;
  assign instr_valid_o = head_valid;
  assign instr_o       = head.instr;
  assign instr_pc_o    = head.pc;

`ifdef PREFETCH_PERF_EN
  logic [15:0] flush_cnt_reg;
  logic [15:0] stall_cnt_reg;

  // Saturating counts of redirect cycles and CPU-starved cycles
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      flush_cnt_reg <= '0;
      stall_cnt_reg <= '0;
    end else begin
      if (redirect_i && (flush_cnt_reg != 16'hFFFF))
        flush_cnt_reg <= flush_cnt_reg + 16'd1;
      if (instr_ready_i && !head_valid && (stall_cnt_reg != 16'hFFFF))
        stall_cnt_reg <= stall_cnt_reg + 16'd1;
    end
  end

  assign flush_cnt_o = flush_cnt_reg;
  assign stall_cnt_o = stall_cnt_reg;
`endif

endmodule

// File: doc/instr_prefetch.md
INSTR_PREFETCH -- requirements
Module: instr_prefetch

Interface
REQ-001 SHALL have parameter DEPTH, default 4, FIFO entries (power of 2, >=2).
REQ-002 SHALL have parameter RESET_PC, default 32'h0000_0000, first fetch address.
REQ-003 SHALL have port clk_i  input  1  sole clock, rising edge.
REQ-004 SHALL have port rst_i  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port start_i  input  1  fetch enable; low blocks new memory requests.
REQ-006 SHALL have port mem_req_o  output  1  instruction memory read request.
REQ-007 SHALL have port mem_addr_o  output  32  word-aligned read address.
REQ-008 SHALL have port mem_ack_i  input  1  read complete; mem_data_i valid this cycle.
REQ-009 SHALL have port mem_data_i  input  32  returned instruction word.
REQ-010 SHALL have port redirect_i  input  1  jump or taken branch from CPU.
REQ-011 SHALL have port redirect_addr_i  input  32  new fetch target.
REQ-012 SHALL have port instr_valid_o  output  1  FIFO head valid.
REQ-013 SHALL have port instr_o  output  32  FIFO head instruction.
REQ-014 SHALL have port instr_pc_o  output  32  address of instr_o.
REQ-015 SHALL have port instr_ready_i  input  1  CPU consumes head when high with instr_valid_o.

Function
REQ-016 SHALL implement FSM states IDLE, FETCH, DRAIN.
REQ-017 IDLE->FETCH when start_i=1 and free slots (DEPTH - count - outstanding) >0; mem_req_o=1, mem_addr_o=fetch_pc.
REQ-018 FETCH: mem_req_o and mem_addr_o SHALL hold stable until mem_ack_i; start_i deassert SHALL NOT cancel it.
REQ-019 On mem_ack_i in FETCH: enqueue {fetch_pc, mem_data_i}, fetch_pc += 4 (mod 2^32, 32'hFFFF_FFFC wraps to 0); back-to-back request next cycle if REQ-017 holds, else IDLE.
REQ-020 Enqueue-to-output latency SHALL be one cycle: ack at edge n -> instr_valid_o high after edge n+1.
REQ-021 Dequeue on instr_valid_o & instr_ready_i; enqueue and dequeue in same cycle SHALL both take effect, count unchanged.
REQ-022 Empty: instr_valid_o=0, instr_o/instr_pc_o hold last value; full: no new request.
REQ-023 redirect_i SHALL clear FIFO (instr_valid_o=0 next cycle), load fetch_pc with {redirect_addr_i[31:2],2'b00}, and outrank same-cycle enqueue/dequeue.
REQ-024 redirect_i with request outstanding and no same-cycle ack: enter DRAIN; hold request to ack, discard that data, then IDLE.
REQ-025 redirect_i with same-cycle ack: discard ack data, go IDLE, no DRAIN.
REQ-026 redirect_i in DRAIN: update fetch_pc only; stay DRAIN.

Reset
REQ-027 rst_i high SHALL immediately force: state IDLE, FIFO empty, fetch_pc=RESET_PC, mem_req_o=0, mem_addr_o=0, instr_valid_o=0, instr_o=0, instr_pc_o=0.
REQ-028 rst_i mid-request SHALL drop mem_req_o; a later mem_ack_i with no request SHALL be ignored.

Configuration
REQ-029 With PREFETCH_PERF_EN defined: add outputs flush_cnt_o (16) counting redirect_i cycles and stall_cnt_o (16) counting instr_ready_i & ~instr_valid_o cycles, saturating at 16'hFFFF, reset 0.
REQ-030 Without PREFETCH_PERF_EN: those ports and counters SHALL not exist; all other behaviour identical.

Structure
REQ-031 Shared package SHALL hold FSM state enum, INSTR_W=32, PC_STEP=4, fetch-entry struct {pc, instr}.
REQ-032 FIFO SHALL be sub-module prefetch_fifo (DEPTH, push/pop/flush, count); FSM and fetch_pc stay in top.

Verification
REQ-033 Reset, start_i=1, ack every cycle, ready=1 -> requests 0x0,0x4,0x8...; instr_pc_o follows with one-cycle latency.
REQ-034 ready=0, zero-latency ack -> exactly 4 entries, mem_req_o low while full; one dequeue -> one new request.
REQ-035 redirect_i to 0x0000_1003 during outstanding request at 0x10 -> DRAIN; ack data dropped; next request 0x0000_1000; no 0x10 word output.
REQ-036 redirect_i and mem_ack_i same cycle -> acked word never appears; next request at redirect address.
REQ-037 RESET_PC=32'hFFFF_FFF8 -> requests 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0000_0000.
REQ-038 rst_i pulsed mid-FETCH with FIFO at 2 -> all outputs 0 that cycle; stray ack ignored; restart from RESET_PC.
